// File: rtl/sig_pkg.sv
// rtl/sig_pkg.sv - shared types and constants for the scan sequencer
package sig_pkg;

  localparam int TIME_W    = 32;
  localparam int SCAN_ID_W = 8;

  localparam logic DIR_LTR = 1'b0;
  localparam logic DIR_RTL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_PAIR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sig_scan_ctrl_if.sv
// rtl/sig_scan_ctrl_if.sv - extractor, pair output and status bundle of the scan sequencer
interface sig_scan_ctrl_if;

  logic                          enable;
  logic                          dir_cfg;
  logic                          sync_pulse;
  logic [sig_pkg::TIME_W-1:0]    sync_time;
  logic                          pair_valid;
  logic [sig_pkg::TIME_W-1:0]    left_time;
  logic [sig_pkg::TIME_W-1:0]    right_time;
  logic                          dir;
  logic [sig_pkg::TIME_W-1:0]    window_start;
  logic                          extract_rst_n;
  logic                          out_valid;
  logic                          out_ready;
  logic [sig_pkg::TIME_W-1:0]    out_left;
  logic [sig_pkg::TIME_W-1:0]    out_right;
  logic                          out_dir;
  logic [sig_pkg::SCAN_ID_W-1:0] out_scan_id;
  logic                          scan_done;
  logic [3:0]                    scan_pairs;
  logic                          scan_timeout;
  logic [15:0]                   drop_count;
  logic                          busy;

  modport slave (
    input  enable, dir_cfg, sync_pulse, sync_time, pair_valid, left_time, right_time, out_ready,
    output dir, window_start, extract_rst_n, out_valid, out_left, out_right, out_dir,
           out_scan_id, scan_done, scan_pairs, scan_timeout, drop_count, busy
  );

  modport master (
    output enable, dir_cfg, sync_pulse, sync_time, pair_valid, left_time, right_time, out_ready,
    input  dir, window_start, extract_rst_n, out_valid, out_left, out_right, out_dir,
           out_scan_id, scan_done, scan_pairs, scan_timeout, drop_count, busy
  );

endinterface

// File: rtl/sig_pair_outreg.sv
// rtl/sig_pair_outreg.sv - one-entry valid/ready pair register with saturating drop counter
module sig_pair_outreg
  import sig_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cap_valid,
  input  logic [TIME_W-1:0]    cap_left,
  input  logic [TIME_W-1:0]    cap_right,
  input  logic                 cap_dir,
  input  logic [SCAN_ID_W-1:0] cap_scan_id,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [TIME_W-1:0]    out_left,
  output logic [TIME_W-1:0]    out_right,
  output logic                 out_dir,
  output logic [SCAN_ID_W-1:0] out_scan_id,
  output logic [15:0]          drop_count
);

  logic                 valid_q, valid_d;
  logic [TIME_W-1:0]    left_q, left_d;
  logic [TIME_W-1:0]    right_q, right_d;
  logic                 dir_q, dir_d;
  logic [SCAN_ID_W-1:0] id_q, id_d;
  logic [15:0]          drop_q, drop_d;

  always_comb begin
    valid_d = valid_q;
    left_d  = left_q;
    right_d = right_q;
    dir_d   = dir_q;
    id_d    = id_q;
    drop_d  = drop_q;
    // a draining entry frees the slot in the same cycle
    if (cap_valid && (!valid_q || out_ready)) begin
      valid_d = 1'b1;
      left_d  = cap_left;
      right_d = cap_right;
      dir_d   = cap_dir;
      id_d    = cap_scan_id;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (cap_valid && valid_q && !out_ready && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      dir_q   <= 1'b0;
      id_q    <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      left_q  <= left_d;
      right_q <= right_d;
      dir_q   <= dir_d;
      id_q    <= id_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_left    = left_q;
  assign out_right   = right_q;
  assign out_dir     = dir_q;
  assign out_scan_id = id_q;
  assign drop_count  = drop_q;

endmodule

// File: rtl/sig_scan_ctrl.sv
// rtl/sig_scan_ctrl.sv - scan sequencer: arms the extractor per sync event and collects sample pairs
module sig_scan_ctrl
  import sig_pkg::*;
#(
  parameter int unsigned       PAIRS_PER_SCAN = 2,
  parameter int unsigned       TIMEOUT_CYC    = 50000,
  parameter logic [TIME_W-1:0] GUARD_TIME     = '0,
  parameter bit                ALTERNATE      = 1'b1
) (
  input logic           clk,
  input logic           reset,
  sig_scan_ctrl_if.slave bus
);

  state_e               state_q, state_d;
  logic                 dir_q, dir_d;
  logic [TIME_W-1:0]    window_q, window_d;
  logic                 ext_rst_n_q, ext_rst_n_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [TIME_W-1:0]    timer_q, timer_d;
  logic                 pending_q, pending_d;
  logic [TIME_W-1:0]    pend_time_q, pend_time_d;
  logic [SCAN_ID_W-1:0] scan_id_q, scan_id_d;
  logic                 scan_done_q, scan_done_d;
  logic [3:0]           scan_pairs_q, scan_pairs_d;
  logic                 scan_timeout_q, scan_timeout_d;

  logic       start, abort, accept, full, expired;
  logic [3:0] cnt_inc;

  assign start   = bus.enable && (bus.sync_pulse || pending_q);
  assign abort   = !bus.enable && ((state_q == ST_ARM) || (state_q == ST_WAIT_PAIR));
  assign accept  = (state_q == ST_WAIT_PAIR) && bus.enable && bus.pair_valid;
  assign cnt_inc = cnt_q + {3'b000, accept};
  assign full    = (cnt_inc == 4'(PAIRS_PER_SCAN));
  assign expired = (timer_q == TIME_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_ARM;
      ST_ARM:       state_d = abort ? ST_IDLE : ST_WAIT_PAIR;
      ST_WAIT_PAIR: begin
        if (abort)                                  state_d = ST_IDLE;
        else if (full || bus.sync_pulse || expired) state_d = ST_DONE;
      end
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dir_d          = dir_q;
    window_d       = window_q;
    ext_rst_n_d    = 1'b1;
    cnt_d          = cnt_q;
    timer_d        = timer_q;
    pending_d      = pending_q;
    pend_time_d    = pend_time_q;
    scan_id_d      = scan_id_q;
    scan_done_d    = 1'b0;
    scan_pairs_d   = scan_pairs_q;
    scan_timeout_d = scan_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // a fresh pulse takes precedence over a latched one
          window_d    = (bus.sync_pulse ? bus.sync_time : pend_time_q) + GUARD_TIME;
          dir_d       = ALTERNATE ? ~dir_q : bus.dir_cfg;
          cnt_d       = '0;
          pending_d   = 1'b0;
          ext_rst_n_d = 1'b0;
        end
      end
      ST_ARM: begin
        timer_d = '0;
        if (abort) begin
          pending_d   = 1'b0;
          ext_rst_n_d = 1'b0;
        end
      end
      ST_WAIT_PAIR: begin
        if (abort) begin
          pending_d   = 1'b0;
          ext_rst_n_d = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
          cnt_d   = cnt_inc;
          if (bus.sync_pulse) begin
            pending_d   = 1'b1;
            pend_time_d = bus.sync_time;
          end
          if (state_d == ST_DONE) begin
            scan_done_d    = 1'b1;
            scan_pairs_d   = cnt_inc;
            scan_timeout_d = expired && !full && !bus.sync_pulse;
          end
        end
      end
      ST_DONE: begin
        scan_id_d = scan_id_q + 1'b1;
        if (bus.sync_pulse) begin
          pending_d   = 1'b1;
          pend_time_d = bus.sync_time;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q          <= DIR_LTR;
      window_q       <= '0;
      ext_rst_n_q    <= 1'b1;
      cnt_q          <= '0;
      timer_q        <= '0;
      pending_q      <= 1'b0;
      pend_time_q    <= '0;
      scan_id_q      <= '0;
      scan_done_q    <= 1'b0;
      scan_pairs_q   <= '0;
      scan_timeout_q <= 1'b0;
    end else begin
      dir_q          <= dir_d;
      window_q       <= window_d;
      ext_rst_n_q    <= ext_rst_n_d;
      cnt_q          <= cnt_d;
      timer_q        <= timer_d;
      pending_q      <= pending_d;
      pend_time_q    <= pend_time_d;
      scan_id_q      <= scan_id_d;
      scan_done_q    <= scan_done_d;
      scan_pairs_q   <= scan_pairs_d;
      scan_timeout_q <= scan_timeout_d;
    end
  end

  sig_pair_outreg u_outreg (
    .clk         (clk),
    .reset       (reset),
    .cap_valid   (accept),
    .cap_left    (bus.left_time),
    .cap_right   (bus.right_time),
    .cap_dir     (dir_q),
    .cap_scan_id (scan_id_q),
    .out_ready   (bus.out_ready),
    .out_valid   (bus.out_valid),
    .out_left    (bus.out_left),
    .out_right   (bus.out_right),
    .out_dir     (bus.out_dir),
    .out_scan_id (bus.out_scan_id),
    .drop_count  (bus.drop_count)
  );

  assign bus.dir           = dir_q;
  assign bus.window_start  = window_q;
  assign bus.extract_rst_n = ext_rst_n_q;
  assign bus.scan_done     = scan_done_q;
  assign bus.scan_pairs    = scan_pairs_q;
  assign bus.scan_timeout  = scan_timeout_q;
  assign bus.busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sig_scan_ctrl.sv
// tb/tb_sig_scan_ctrl.sv - directed self-checking bench for sig_scan_ctrl
module tb_sig_scan_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic early_done;

  sig_scan_ctrl_if bus ();

  sig_scan_ctrl #(
    .PAIRS_PER_SCAN (2),
    .TIMEOUT_CYC    (100),
    .GUARD_TIME     (32'd20),
    .ALTERNATE      (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input logic [31:0] l, input logic [31:0] r);
    bus.pair_valid = 1'b1;
    bus.left_time  = l;
    bus.right_time = r;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.enable = 1'b0; bus.dir_cfg = 1'b0; bus.sync_pulse = 1'b0; bus.sync_time = '0;
    bus.pair_valid = 1'b0; bus.left_time = '0; bus.right_time = '0; bus.out_ready = 1'b1;
    tick(); tick();
    chk("rst_dir", bus.dir, 0);
    chk("rst_window", bus.window_start, 0);
    chk("rst_ext_n", bus.extract_rst_n, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_drop", bus.drop_count, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;
    bus.enable = 1'b1;
    tick();

    // scan 0: basic two-pair scan
    bus.sync_pulse = 1'b1; bus.sync_time = 32'd1000;
    tick();
    bus.sync_pulse = 1'b0;
    chk("s0_window", bus.window_start, 32'd1020);
    chk("s0_dir", bus.dir, 1);
    chk("s0_ext_low", bus.extract_rst_n, 0);
    chk("s0_busy", bus.busy, 1);
    tick();
    chk("s0_ext_high", bus.extract_rst_n, 1);
    pair(32'd1100, 32'd1050);
    tick();
    chk("s0_p1_valid", bus.out_valid, 1);
    chk("s0_p1_left", bus.out_left, 32'd1100);
    chk("s0_p1_right", bus.out_right, 32'd1050);
    chk("s0_p1_dir", bus.out_dir, 1);
    chk("s0_p1_id", bus.out_scan_id, 0);
    pair(32'd1300, 32'd1250);
    tick();
    bus.pair_valid = 1'b0;
    chk("s0_p2_left", bus.out_left, 32'd1300);
    chk("s0_p2_right", bus.out_right, 32'd1250);
    chk("s0_done", bus.scan_done, 1);
    chk("s0_pairs", bus.scan_pairs, 2);
    chk("s0_timeout", bus.scan_timeout, 0);
    tick();
    chk("s0_drained", bus.out_valid, 0);
    chk("s0_done_end", bus.scan_done, 0);
    chk("s0_idle", bus.busy, 0);

    // scan 1: timeout after 100 cycles in WAIT_PAIR
    bus.sync_pulse = 1'b1; bus.sync_time = 32'd2000;
    tick();
    bus.sync_pulse = 1'b0;
    chk("s1_dir", bus.dir, 0);
    chk("s1_window", bus.window_start, 32'd2020);
    tick();
    early_done = 1'b0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (bus.scan_done) early_done = 1'b1;
    end
    chk("s1_no_early_done", early_done, 0);
    tick();
    chk("s1_done", bus.scan_done, 1);
    chk("s1_timeout", bus.scan_timeout, 1);
    chk("s1_pairs", bus.scan_pairs, 0);
    tick();

    // scan 2: backpressure, one held and one dropped
    bus.out_ready = 1'b0;
    bus.sync_pulse = 1'b1; bus.sync_time = 32'd3000;
    tick();
    bus.sync_pulse = 1'b0;
    chk("s2_dir", bus.dir, 1);
    tick();
    pair(32'd10, 32'd11);
    tick();
    chk("s2_p1_left", bus.out_left, 32'd10);
    chk("s2_p1_id", bus.out_scan_id, 2);
    pair(32'd20, 32'd21);
    tick();
    bus.pair_valid = 1'b0;
    chk("s2_drop", bus.drop_count, 1);
    chk("s2_done", bus.scan_done, 1);
    chk("s2_pairs", bus.scan_pairs, 2);
    tick();

    // scan 3: one dropped pair then preempted by sync at 5000
    bus.sync_pulse = 1'b1; bus.sync_time = 32'd4000;
    tick();
    bus.sync_pulse = 1'b0;
    chk("s3_dir", bus.dir, 0);
    tick();
    pair(32'd30, 32'd31);
    tick();
    bus.pair_valid = 1'b0;
    chk("s3_drop", bus.drop_count, 2);
    chk("s3_held_left", bus.out_left, 32'd10);
    chk("s3_held_valid", bus.out_valid, 1);
    bus.sync_pulse = 1'b1; bus.sync_time = 32'd5000;
    tick();
    bus.sync_pulse = 1'b0;
    chk("s3_done", bus.scan_done, 1);
    chk("s3_pairs", bus.scan_pairs, 1);
    chk("s3_timeout", bus.scan_timeout, 0);
    tick();
    chk("s3_idle", bus.busy, 0);
    tick();

    // scan 4: started from the latched sync
    chk("s4_window", bus.window_start, 32'd5020);
    chk("s4_dir", bus.dir, 1);
    chk("s4_ext_low", bus.extract_rst_n, 0);
    bus.out_ready = 1'b1;
    tick();
    chk("s4_release", bus.out_valid, 0);
    pair(32'd40, 32'd41);
    tick();
    chk("s4_p1_left", bus.out_left, 32'd40);
    pair(32'd50, 32'd51);
    tick();
    bus.pair_valid = 1'b0;
    chk("s4_simul_valid", bus.out_valid, 1);
    chk("s4_simul_left", bus.out_left, 32'd50);
    chk("s4_simul_id", bus.out_scan_id, 4);
    chk("s4_simul_drop", bus.drop_count, 2);
    chk("s4_done", bus.scan_done, 1);
    tick();

    // scan 5: window wrap, then disable mid-scan
    bus.sync_pulse = 1'b1; bus.sync_time = 32'hFFFF_FFF0;
    tick();
    bus.sync_pulse = 1'b0;
    chk("s5_wrap", bus.window_start, 32'h0000_0004);
    chk("s5_dir", bus.dir, 0);
    tick();
    pair(32'd60, 32'd61);
    tick();
    bus.pair_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.enable = 1'b0;
    tick();
    chk("s5_dis_idle", bus.busy, 0);
    chk("s5_dis_no_done", bus.scan_done, 0);
    chk("s5_dis_ext_low", bus.extract_rst_n, 0);
    chk("s5_dis_keep_left", bus.out_left, 32'd60);
    chk("s5_dis_keep_id", bus.out_scan_id, 5);
    tick();
    chk("s5_dis_ext_high", bus.extract_rst_n, 1);
    chk("s5_dis_keep_valid", bus.out_valid, 1);

    // async reset in the middle of WAIT_PAIR
    bus.enable = 1'b1;
    bus.sync_pulse = 1'b1; bus.sync_time = 32'd7000;
    tick();
    bus.sync_pulse = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_busy", bus.busy, 0);
    chk("ar_dir", bus.dir, 0);
    chk("ar_window", bus.window_start, 0);
    chk("ar_out_valid", bus.out_valid, 0);
    chk("ar_out_left", bus.out_left, 0);
    chk("ar_drop", bus.drop_count, 0);
    chk("ar_ext_n", bus.extract_rst_n, 1);
    tick();
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
